// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - load/store request and response bus between CPU MEM stage and data memory
interface data_mem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] txn_count;

   modport master (
      output req_valid, req_write, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err, txn_count
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err, txn_count
   );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - multi-cycle word-addressed data memory answering one load/store after LATENCY cycles
module data_mem_responder #(
   parameter int DEPTH_LOG2 = 10,
   parameter int LATENCY    = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   data_mem_responder_if.slave  bus
);
   localparam int AW = DEPTH_LOG2 + 2;

   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              write_q;
   logic [AW-1:0]     addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;
   logic [31:0]       txn_q;
   logic [31:0]       mem_q [2**DEPTH_LOG2];

   logic              accept;
   logic              enter_resp;
   logic              c_write;
   logic [AW-1:0]     c_addr;
   logic [31:0]       c_wdata;
   logic [DEPTH_LOG2-1:0] c_idx;
   logic              c_misaligned;

   assign accept     = (state_q == IDLE) && bus.req_valid;
   assign enter_resp = (state_d == RESP) && (state_q != RESP);

   // With LATENCY==1 the commit edge is the accept edge, so the live request is used.
   assign c_write      = (state_q == IDLE) ? bus.req_write          : write_q;
   assign c_addr       = (state_q == IDLE) ? bus.req_addr[AW-1:0]   : addr_q;
   assign c_wdata      = (state_q == IDLE) ? bus.req_wdata          : wdata_q;
   assign c_idx        = c_addr[AW-1:2];
   assign c_misaligned = |c_addr[1:0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (LATENCY == 1) begin
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
                  cnt_d   = 4'(LATENCY - 1);
               end
            end
         end
         WAIT: begin
            if (cnt_q == 4'd1) state_d = RESP;
            else               cnt_d   = cnt_q - 4'd1;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      case (state_q)
         IDLE:    bus.req_ready  = 1'b1;
         RESP:    bus.resp_valid = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      rdata_d = rdata_q;
      err_d   = err_q;
      if (enter_resp) begin
         err_d   = c_misaligned;
         rdata_d = (c_misaligned || c_write) ? 32'd0 : mem_q[c_idx];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         txn_q   <= '0;
      end else begin
         if (accept) begin
            write_q <= bus.req_write;
            addr_q  <= bus.req_addr[AW-1:0];
            wdata_q <= bus.req_wdata;
         end
         rdata_q <= rdata_d;
         err_q   <= err_d;
         if (state_q == RESP) txn_q <= txn_q + 32'd1;
      end
   end

   // Storage is not reset; the reset gate only blocks a commit while reset is held.
   always_ff @(posedge clk) begin
      if (reset && enter_resp && c_write && !c_misaligned) mem_q[c_idx] <= c_wdata;
   end

   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err   = err_q;
   assign bus.txn_count  = txn_q;
endmodule
